// File: rtl/fetch_queue_pkg.sv
// Shared core package for the instruction fetch queue: default widths,
// reset fetch address, bundle widths and small helpers.
package fetch_queue_pkg;

    // Default instruction word-address and instruction widths.
    localparam int FQ_AW = 30;
    localparam int FQ_DW = 32;

    // Default first fetch word address after reset.
    localparam logic [FQ_AW-1:0] FQ_RESET_ADDR = '0;

    // Redirect bundle {valid, target} and decode-side valid bundle
    // {valid, addr, instr} widths at the default sizes.
    localparam int FQ_REDIR_W = 1 + FQ_AW;
    localparam int FQ_VALID_W = 1 + FQ_AW + FQ_DW;

    typedef struct packed {
        logic             valid;
        logic [FQ_AW-1:0] addr;
    } fq_redir_t;

    typedef struct packed {
        logic             valid;
        logic [FQ_AW-1:0] addr;
        logic [FQ_DW-1:0] instr;
    } fq_out_t;

    // Width of an occupancy counter that must represent 0..depth.
    function automatic int fq_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and combinational head.
// A flush empties the queue in one cycle and wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_reg;
    logic [PW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             full;
    logic             wr_en;
    logic             rd_en;

    // Occupancy and status derived from the wrap-bit pointer pair.
    always_comb begin
        count     = wr_ptr_reg - rd_ptr_reg;
        empty     = (wr_ptr_reg == rd_ptr_reg);
        full      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                    (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
        wr_en     = push && !full && !flush;
        rd_en     = pop && !empty && !flush;
        head_data = mem_reg[rd_ptr_reg[PW-1:0]];
    end

    // Pointer update; flush collapses both pointers back to zero.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_reg[wr_ptr_reg[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches while credit
// remains, captures each response one cycle later into a small FIFO and
// hands entries to decode. Redirects flush everything and restart the PC.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              AW         = FQ_AW,
    parameter int              DW         = FQ_DW,
    parameter int              DEPTH      = 4,     // power of two, >= 2
    parameter logic [AW-1:0]   RESET_ADDR = AW'(FQ_RESET_ADDR),
    parameter bit              BYPASS     = 1'b0
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    output logic                        IREQ,
    output logic [AW-1:0]               IADDR,
    input  logic [DW-1:0]               INSTR,
    input  logic                        REDIR_VALID,
    input  logic [AW-1:0]               REDIR_ADDR,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [DW-1:0]               OUT_INSTR,
    output logic [AW-1:0]               OUT_ADDR,
    output logic [$clog2(DEPTH):0]      COUNT
);

    localparam int CW = fq_count_w(DEPTH);
    localparam int EW = AW + DW;

    logic [AW-1:0] pc_reg;
    logic [AW-1:0] resp_addr_reg;
    logic          inflight_reg;

    logic [CW:0]   occupancy;
    logic          arriving;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] head_data;

    // Credit check, response routing and decode-side presentation.
    // IREQ is held low while reset is asserted so nothing issues early.
    always_comb begin
        occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
        IREQ        = RSTN && !REDIR_VALID && (occupancy < (CW+1)'(DEPTH));
        IADDR       = pc_reg;
        arriving    = inflight_reg && !REDIR_VALID;
        bypass_take = BYPASS && fifo_empty && arriving && OUT_READY;
        push        = arriving && !bypass_take;
        pop         = !fifo_empty && OUT_READY && !REDIR_VALID;
        COUNT       = fifo_count;
        OUT_VALID   = 1'b0;
        OUT_ADDR    = '0;
        OUT_INSTR   = '0;
        if (!REDIR_VALID) begin
            if (!fifo_empty) begin
                OUT_VALID             = 1'b1;
                {OUT_ADDR, OUT_INSTR} = head_data;
            end else if (BYPASS && arriving) begin
                OUT_VALID = 1'b1;
                OUT_ADDR  = resp_addr_reg;
                OUT_INSTR = INSTR;
            end
        end
    end

    // Fetch PC and in-flight tracking; a redirect kills the outstanding
    // response and reloads the PC, taking priority over a new issue.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_reg        <= RESET_ADDR;
            resp_addr_reg <= '0;
            inflight_reg  <= 1'b0;
        end else if (REDIR_VALID) begin
            pc_reg       <= REDIR_ADDR;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= IREQ;
            if (IREQ) begin
                pc_reg        <= pc_reg + AW'(1);
                resp_addr_reg <= pc_reg;
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .flush     (REDIR_VALID),
        .push      (push),
        .push_data ({resp_addr_reg, INSTR}),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table on the default
// instance plus hand-written sequences for wrap, bypass and mid-fetch reset.
module tb_fetch_queue;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RSTN;
    logic        OUT_READY;
    logic        REDIR_VALID;
    logic [29:0] REDIR_ADDR;

    logic        ireq   [3];
    logic [29:0] iaddr  [3];
    logic [31:0] instr  [3];
    logic        ov     [3];
    logic [31:0] oinstr [3];
    logic [29:0] oaddr  [3];
    logic [2:0]  cnt    [3];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] instr_of(input logic [29:0] a);
        return {2'b01, a} ^ 32'h00A5_5A00;
    endfunction

    // Instruction memory: answers one cycle after each request, junk otherwise.
    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++)
            instr[k] <= ireq[k] ? instr_of(iaddr[k]) : 32'hDEAD_BEEF;
    end

    fetch_queue u_dut0 (
        .CLK(CLK), .RSTN(RSTN), .IREQ(ireq[0]), .IADDR(iaddr[0]), .INSTR(instr[0]),
        .REDIR_VALID(REDIR_VALID), .REDIR_ADDR(REDIR_ADDR), .OUT_VALID(ov[0]),
        .OUT_READY(OUT_READY), .OUT_INSTR(oinstr[0]), .OUT_ADDR(oaddr[0]), .COUNT(cnt[0])
    );

    fetch_queue #(.RESET_ADDR(30'h3FFF_FFFF)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN), .IREQ(ireq[1]), .IADDR(iaddr[1]), .INSTR(instr[1]),
        .REDIR_VALID(REDIR_VALID), .REDIR_ADDR(REDIR_ADDR), .OUT_VALID(ov[1]),
        .OUT_READY(OUT_READY), .OUT_INSTR(oinstr[1]), .OUT_ADDR(oaddr[1]), .COUNT(cnt[1])
    );

    fetch_queue #(.BYPASS(1'b1)) u_dut2 (
        .CLK(CLK), .RSTN(RSTN), .IREQ(ireq[2]), .IADDR(iaddr[2]), .INSTR(instr[2]),
        .REDIR_VALID(REDIR_VALID), .REDIR_ADDR(REDIR_ADDR), .OUT_VALID(ov[2]),
        .OUT_READY(OUT_READY), .OUT_INSTR(oinstr[2]), .OUT_ADDR(oaddr[2]), .COUNT(cnt[2])
    );

    typedef struct packed {
        logic        rstn;
        logic        ready;
        logic        rv;
        logic [29:0] ra;
        logic        e_ireq;
        logic [29:0] e_iaddr;
        logic        e_ov;
        logic [29:0] e_oaddr;
        logic [2:0]  e_cnt;
        logic        chk_data;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rstn, input logic ready, input logic rv,
                       input logic [29:0] ra, input logic e_ireq,
                       input logic [29:0] e_iaddr, input logic e_ov,
                       input logic [29:0] e_oaddr, input logic [2:0] e_cnt,
                       input logic chk_data);
        vec_t v;
        v.rstn = rstn; v.ready = ready; v.rv = rv; v.ra = ra;
        v.e_ireq = e_ireq; v.e_iaddr = e_iaddr; v.e_ov = e_ov;
        v.e_oaddr = e_oaddr; v.e_cnt = e_cnt; v.chk_data = chk_data;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then sample at the falling edge.
    task automatic step(input logic rstn, input logic ready, input logic rv,
                        input logic [29:0] ra);
        @(posedge CLK);
        #1;
        RSTN        = rstn;
        OUT_READY   = ready;
        REDIR_VALID = rv;
        REDIR_ADDR  = ra;
        @(negedge CLK);
    endtask

    initial begin
        RSTN        = 1'b0;
        OUT_READY   = 1'b0;
        REDIR_VALID = 1'b0;
        REDIR_ADDR  = '0;

        // rstn ready rv ra | ireq iaddr ov oaddr cnt chk
        // Streaming from reset with decode always ready.
        add(0,1,0,30'h0,   0,30'h0,   0,30'h0,   3'd0,1);
        add(1,1,0,30'h0,   1,30'h0,   0,30'h0,   3'd0,0);
        add(1,1,0,30'h0,   1,30'h1,   0,30'h0,   3'd0,0);
        add(1,1,0,30'h0,   1,30'h2,   1,30'h0,   3'd1,1);
        add(1,1,0,30'h0,   1,30'h3,   1,30'h1,   3'd1,1);
        add(1,1,0,30'h0,   1,30'h4,   1,30'h2,   3'd1,1);
        // Decode stalled from reset: queue fills to 4, one pop frees one slot.
        add(0,0,0,30'h0,   0,30'h0,   0,30'h0,   3'd0,1);
        add(1,0,0,30'h0,   1,30'h0,   0,30'h0,   3'd0,0);
        add(1,0,0,30'h0,   1,30'h1,   0,30'h0,   3'd0,0);
        add(1,0,0,30'h0,   1,30'h2,   1,30'h0,   3'd1,1);
        add(1,0,0,30'h0,   1,30'h3,   1,30'h0,   3'd2,1);
        add(1,0,0,30'h0,   0,30'h4,   1,30'h0,   3'd3,1);
        add(1,0,0,30'h0,   0,30'h4,   1,30'h0,   3'd4,1);
        add(1,1,0,30'h0,   0,30'h4,   1,30'h0,   3'd4,1);
        add(1,0,0,30'h0,   1,30'h4,   1,30'h1,   3'd3,1);
        // Redirect to 0x100 with COUNT=3 and a fetch in flight.
        add(1,0,1,30'h100, 0,30'h5,   0,30'h0,   3'd3,0);
        add(1,0,0,30'h0,   1,30'h100, 0,30'h0,   3'd0,0);
        add(1,0,0,30'h0,   1,30'h101, 0,30'h0,   3'd0,0);
        add(1,0,0,30'h0,   1,30'h102, 1,30'h100, 3'd1,1);
        // Back-to-back redirects: only the second target is fetched.
        add(1,0,1,30'h10,  0,30'h103, 0,30'h0,   3'd2,0);
        add(1,0,1,30'h20,  0,30'h10,  0,30'h0,   3'd0,0);
        add(1,1,0,30'h0,   1,30'h20,  0,30'h0,   3'd0,0);
        add(1,1,0,30'h0,   1,30'h21,  0,30'h0,   3'd0,0);
        add(1,1,0,30'h0,   1,30'h22,  1,30'h20,  3'd1,1);
        add(1,1,0,30'h0,   1,30'h23,  1,30'h21,  3'd1,1);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].rstn, vt[i].ready, vt[i].rv, vt[i].ra);
            $display("vec %0d ireq=%0b iaddr=%h ov=%0b oaddr=%h count=%0d",
                     i, ireq[0], iaddr[0], ov[0], oaddr[0], cnt[0]);
            chk($sformatf("v%0d.ireq", i),  32'(ireq[0]),  32'(vt[i].e_ireq));
            chk($sformatf("v%0d.iaddr", i), 32'(iaddr[0]), 32'(vt[i].e_iaddr));
            chk($sformatf("v%0d.ovalid", i), 32'(ov[0]),   32'(vt[i].e_ov));
            chk($sformatf("v%0d.count", i), 32'(cnt[0]),   32'(vt[i].e_cnt));
            if (vt[i].chk_data) begin
                chk($sformatf("v%0d.oaddr", i), 32'(oaddr[0]), 32'(vt[i].e_oaddr));
                chk($sformatf("v%0d.oinstr", i), oinstr[0],
                    vt[i].e_ov ? instr_of(vt[i].e_oaddr) : 32'h0);
            end
        end

        // Wrap of the fetch PC from all-ones, and bypass with decode ready.
        step(0,1,0,30'h0);
        chk("wrap.rst_iaddr", 32'(iaddr[1]), 32'h3FFF_FFFF);
        step(1,1,0,30'h0);
        $display("seq wrap c0 iaddr=%h byp_ov=%0b", iaddr[1], ov[2]);
        chk("wrap.c0_iaddr", 32'(iaddr[1]), 32'h3FFF_FFFF);
        chk("wrap.c0_ireq",  32'(ireq[1]),  32'h1);
        chk("byp.c0_ov",     32'(ov[2]),    32'h0);
        step(1,1,0,30'h0);
        $display("seq wrap c1 iaddr=%h byp_ov=%0b byp_oaddr=%h", iaddr[1], ov[2], oaddr[2]);
        chk("wrap.c1_iaddr", 32'(iaddr[1]), 32'h0);
        chk("byp.c1_ov",     32'(ov[2]),    32'h1);
        chk("byp.c1_oaddr",  32'(oaddr[2]), 32'h0);
        chk("byp.c1_oinstr", oinstr[2],     instr_of(30'h0));
        chk("byp.c1_count",  32'(cnt[2]),   32'h0);
        step(1,1,0,30'h0);
        $display("seq wrap c2 iaddr=%h oaddr=%h", iaddr[1], oaddr[1]);
        chk("wrap.c2_iaddr", 32'(iaddr[1]), 32'h1);
        chk("wrap.c2_ov",    32'(ov[1]),    32'h1);
        chk("wrap.c2_oaddr", 32'(oaddr[1]), 32'h3FFF_FFFF);
        chk("wrap.c2_oinstr", oinstr[1],    instr_of(30'h3FFF_FFFF));
        chk("byp.c2_oaddr",  32'(oaddr[2]), 32'h1);
        chk("byp.c2_count",  32'(cnt[2]),   32'h0);

        // Bypass with decode stalled: the presented entry is kept and held.
        step(0,0,0,30'h0);
        step(1,0,0,30'h0);
        chk("bst.c0_ov", 32'(ov[2]), 32'h0);
        step(1,0,0,30'h0);
        $display("seq bst c1 ov=%0b oaddr=%h count=%0d", ov[2], oaddr[2], cnt[2]);
        chk("bst.c1_ov",    32'(ov[2]),    32'h1);
        chk("bst.c1_oaddr", 32'(oaddr[2]), 32'h0);
        chk("bst.c1_count", 32'(cnt[2]),   32'h0);
        step(1,0,0,30'h0);
        chk("bst.c2_oaddr", 32'(oaddr[2]), 32'h0);
        chk("bst.c2_count", 32'(cnt[2]),   32'h1);
        step(1,1,0,30'h0);
        chk("bst.c3_oaddr", 32'(oaddr[2]), 32'h0);
        chk("bst.c3_count", 32'(cnt[2]),   32'h2);
        step(1,1,0,30'h0);
        $display("seq bst c4 ov=%0b oaddr=%h count=%0d", ov[2], oaddr[2], cnt[2]);
        chk("bst.c4_oaddr", 32'(oaddr[2]), 32'h1);
        chk("bst.c4_count", 32'(cnt[2]),   32'h2);

        // Reset asserted while a fetch is outstanding: its response is lost.
        step(0,0,0,30'h0);
        step(1,0,0,30'h0);
        chk("mrst.pre_ireq", 32'(ireq[0]), 32'h1);
        step(0,0,0,30'h0);
        $display("seq mrst in-reset ireq=%0b count=%0d", ireq[0], cnt[0]);
        chk("mrst.in_ireq",  32'(ireq[0]), 32'h0);
        chk("mrst.in_count", 32'(cnt[0]),  32'h0);
        step(1,0,0,30'h0);
        chk("mrst.c0_iaddr", 32'(iaddr[0]), 32'h0);
        chk("mrst.c0_count", 32'(cnt[0]),   32'h0);
        step(1,0,0,30'h0);
        chk("mrst.c1_count", 32'(cnt[0]),   32'h0);
        chk("mrst.c1_ov",    32'(ov[0]),    32'h0);
        step(1,0,0,30'h0);
        $display("seq mrst c2 ov=%0b oaddr=%h count=%0d", ov[0], oaddr[0], cnt[0]);
        chk("mrst.c2_count", 32'(cnt[0]),   32'h1);
        chk("mrst.c2_oaddr", 32'(oaddr[0]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter AW, default 30, giving the instruction word-address width.
REQ-002 SHALL have parameter DW, default 32, giving the instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, giving queue entries; power of two and >= 2.
REQ-004 SHALL have parameter RESET_ADDR, default 0, giving the first fetch word address.
REQ-005 SHALL have parameter BYPASS, default 0; 1 means an empty-queue response is presented combinationally.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-007 SHALL have port CLK  in  1  clock, all state on posedge.
REQ-008 SHALL have port RSTN  in  1  asynchronous active-low reset.
REQ-009 SHALL have port IREQ  out  1  instruction memory request.
REQ-010 SHALL have port IADDR  out  AW  word address of the request.
REQ-011 SHALL have port INSTR  in  DW  memory data, valid exactly one cycle after IREQ.
REQ-012 SHALL have port REDIR_VALID  in  1  branch/jump redirect strobe.
REQ-013 SHALL have port REDIR_ADDR  in  AW  redirect target word address.
REQ-014 SHALL have port OUT_VALID  out  1  head entry valid to decode.
REQ-015 SHALL have port OUT_READY  in  1  decode accepts the head entry.
REQ-016 SHALL have port OUT_INSTR  out  DW  head instruction.
REQ-017 SHALL have port OUT_ADDR  out  AW  word address of the head instruction.
REQ-018 SHALL have port COUNT  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 SHALL assert IREQ only when occupancy + in-flight < DEPTH and REDIR_VALID=0.
REQ-020 SHALL drive IADDR = fetch PC and increment the PC by 1 modulo 2^AW per issued IREQ; all-ones wraps to 0.
REQ-021 SHALL capture INSTR with its address into the tail one cycle after IREQ; at most one response is in flight.
REQ-022 SHALL pop the head on OUT_VALID & OUT_READY; push and pop in the same cycle leave COUNT unchanged.
REQ-023 SHALL hold OUT_INSTR/OUT_ADDR stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 SHALL, with BYPASS=0, raise OUT_VALID the cycle after capture (IREQ to OUT_VALID = 2 cycles).
REQ-025 SHALL, with BYPASS=1 and an empty queue, present the arriving response on OUT_* in its capture cycle and store it only if not popped.
REQ-026 SHALL, on REDIR_VALID, flush all entries, discard any in-flight response, load PC := REDIR_ADDR and force OUT_VALID=0 that cycle.
REQ-027 SHALL give redirect priority over push and pop in the same cycle; the first IREQ to REDIR_ADDR issues the next cycle.
REQ-028 SHALL, on back-to-back redirects, use only the last REDIR_ADDR.
REQ-029 SHALL never overflow or underflow; COUNT ranges over 0..DEPTH.

Reset
REQ-030 SHALL on RSTN=0 immediately set PC=RESET_ADDR, COUNT=0, in-flight=0, IREQ=0, OUT_VALID=0, OUT_INSTR=0, OUT_ADDR=0.
REQ-031 SHALL, when reset asserts mid-fetch, drop the outstanding response and not capture it after release.
REQ-032 SHALL issue the first IREQ (IADDR=RESET_ADDR) on the first posedge-evaluated cycle after RSTN rises.

Structure
REQ-033 SHALL place RESET_ADDR default, AW/DW defaults and the redirect/valid bundle widths in the shared core package.
REQ-034 SHALL instantiate one sub-module, sync_fifo (DEPTH x (AW+DW), wrap-bit pointers), for storage; PC, credit and kill logic stay in fetch_queue.

Verification
REQ-035 SHALL check reset release with OUT_READY=1 and no redirect: IADDR 0,1,2,... each cycle; OUT_ADDR=0 appears 2 cycles after the first IREQ; throughput is 1 per cycle.
REQ-036 SHALL check OUT_READY=0 from reset with DEPTH=4: exactly 4 IREQs (0..3), IREQ then stays 0 and COUNT=4; one pop re-enables one IREQ at address 4.
REQ-037 SHALL check REDIR_VALID with REDIR_ADDR=0x100 while COUNT=3 and one fetch is in flight: the next cycle COUNT=0, the stale response is dropped, IADDR=0x100, and the first OUT_ADDR is 0x100.
REQ-038 SHALL check redirects to 0x10 then 0x20 on consecutive cycles: no fetch of 0x10 issues and the first OUT_ADDR is 0x20.
REQ-039 SHALL check RESET_ADDR=0x3FFFFFFF, AW=30: the IADDR sequence is 0x3FFFFFFF, 0x0, 0x1.
REQ-040 SHALL check BYPASS=1 with an empty queue and OUT_READY=1: OUT_VALID rises the cycle after IREQ, and COUNT stays 0.
